lcd_fb_arbiter: RTL
===================

// Module: lcd_fb_arbiter
// PURPOSE
//  Schedules the single frame-buffer memory port between the LCD display read path and the camera write path.
//  Issues burst commands: reads keep the display read FIFO above a low-water mark; writes drain the camera FIFO.
//  Manages ping-pong frame banks so the display always scans the last complete camera frame.
//  Sits between the FIFOs feeding/draining the 800x480 LCD timing generator and the memory controller.
// PARAMETERS
//  ADDR_W       22       memory word-address width
//  FIFO_LW      10       FIFO level width
//  LEN_W        9        mem_len width
//  FRAME_WORDS  307200   words per frame (640x480 active window)
//  BURST_LEN    256      max words per burst (<= 2**LEN_W-1)
//  BANK_OFFSET  22'h080000  base of bank 1 (bank 0 base = 0)
//  RD_LOW_TH    256      read burst wanted when rd_fifo_level < RD_LOW_TH
//  MAX_RD_RUN   4        max consecutive read grants while a write is pending
// PORTS
//  clk              in   1        system clock
//  rst              in   1        asynchronous, active-high reset
//  lcd_frame_start  in   1        1-cycle pulse, display frame begins
//  rd_fifo_level    in   FIFO_LW  words held in display read FIFO
//  cam_frame_start  in   1        1-cycle pulse, camera frame begins
//  wr_fifo_level    in   FIFO_LW  words held in camera write FIFO
//  mem_req          out  1        command valid
//  mem_wr           out  1        1 = write burst, 0 = read burst
//  mem_addr         out  ADDR_W   burst start word address
//  mem_len          out  LEN_W    burst length in words
//  mem_ack          in   1        command accepted (sampled while mem_req=1)
//  mem_done         in   1        1-cycle pulse, burst data transfer complete
//  rd_bank          out  1        bank being displayed
//  wr_bank          out  1        bank being written
//  frame_drop       out  1        1-cycle pulse, camera frame aborted incomplete
//  busy             out  1        FSM not in IDLE
// BEHAVIOUR
//  - Reset: mem_req/mem_wr/frame_drop/busy=0; mem_addr/mem_len=0; rd_bank=0; wr_bank=1; last_done_bank=0.
//    Read/write active flags and pending-start flags cleared; offsets 0.
//  - States: IDLE, RD_CMD, RD_WAIT, WR_CMD, WR_WAIT. All outputs registered.
//  - Frame starts are latched as pending and applied only in IDLE, before arbitration.
//    In-flight bursts always finish normally.
//  - Apply lcd start: rd_bank<=last_done_bank, rd_off<=0, rd_active<=1.
//  - Apply cam start: if wr_active (frame incomplete), pulse frame_drop and keep wr_bank.
//    Else wr_bank<=~rd_bank. Then wr_off<=0, wr_active<=1.
//  - Both pending the same cycle: apply lcd first, then cam, so wr_bank uses the new rd_bank.
//  - rd_need = rd_active & rd_fifo_level<RD_LOW_TH.
//  - wr_need = wr_active & wr_fifo_level>=len_w, where len_w=min(BURST_LEN, FRAME_WORDS-wr_off).
//  - Arbitration in IDLE: read wins, unless wr_need and rd_run==MAX_RD_RUN, which grants write.
//    rd_run +1 per read grant; cleared on write grant or when wr_need=0.
//  - Grant: next cycle enters *_CMD with mem_req=1 and mem_addr=bank*BANK_OFFSET+off.
//    mem_len=min(BURST_LEN, words left). Latency from need to mem_req: 1 cycle.
//  - *_CMD: hold mem_req, mem_addr, mem_wr, mem_len stable until mem_ack. On mem_ack: mem_req<=0, go to *_WAIT.
//    mem_ack & mem_done in the same cycle: complete immediately and go to IDLE.
//  - *_WAIT: on mem_done, off+=mem_len, go to IDLE. mem_done outside CMD/WAIT is ignored.
//  - Read off reaches FRAME_WORDS: rd_active<=0 (no reads until next lcd start).
//  - Write off reaches FRAME_WORDS: wr_active<=0, last_done_bank<=wr_bank.
//  - Offset arithmetic is ADDR_W bits; the final burst is shortened, never wraps past FRAME_WORDS.
//  - Async rst mid-burst: return to the reset state at once; the memory controller must be reset with it.
// STRUCTURE
//  - Package fb_arb_pkg: state enum, burst-length min function, default constants.
//  - Sub-module fb_frame_counter: offset, words-left, next-len, done flag. Instantiated for read and write.
//  - Top holds FSM, pending flags, bank logic, rd_run counter.
// TESTING
//  1 Reset, then lcd_frame_start, rd_fifo_level=0 -> mem_req=1 the 2nd cycle; mem_wr=0, mem_addr=0, mem_len=256.
//  2 Hold mem_ack low 5 cycles -> mem_req/addr/len stable; ack+done same cycle -> IDLE, next read addr=256.
//  3 Full write frame (1200 bursts of 256) -> last_done_bank=1; next lcd start -> rd_bank=1, first addr=0x080000.
//  4 rd_fifo_level=0, wr_fifo_level=300 both continuous -> grants R,R,R,R,W repeating.
//  5 cam_frame_start after 10 write bursts -> frame_drop pulse; wr restarts offset 0 in same bank.
//  6 FRAME_WORDS=300, BURST_LEN=256 -> bursts of 256 then 44; rst asserted in RD_WAIT -> all outputs at reset values.

Source files
------------

// File: rtl/fb_arb_pkg.sv
// Shared types and defaults for the LCD frame-buffer arbiter.
// Includes the burst-length clamp used by both frame counters.
package fb_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_CMD,
        ST_RD_WAIT,
        ST_WR_CMD,
        ST_WR_WAIT
    } arb_state_e;

    localparam int unsigned DEF_ADDR_W      = 22;
    localparam int unsigned DEF_FIFO_LW     = 10;
    localparam int unsigned DEF_LEN_W       = 9;
    localparam int unsigned DEF_FRAME_WORDS = 307200;
    localparam int unsigned DEF_BURST_LEN   = 256;
    localparam int unsigned DEF_BANK_OFFSET = 32'h0008_0000;
    localparam int unsigned DEF_RD_LOW_TH   = 256;
    localparam int unsigned DEF_MAX_RD_RUN  = 4;

    function automatic int unsigned burst_len_min(input int unsigned left,
                                                  input int unsigned max_len);
        return (left < max_len) ? left : max_len;
    endfunction

endpackage

// File: rtl/fb_frame_counter.sv
// Word offset within one frame, plus the length of the next burst.
// A clear takes effect combinationally so a grant in the same cycle starts at offset 0.
module fb_frame_counter
    import fb_arb_pkg::*;
#(
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    parameter int unsigned LEN_W       = DEF_LEN_W,
    parameter int unsigned FRAME_WORDS = DEF_FRAME_WORDS,
    parameter int unsigned BURST_LEN   = DEF_BURST_LEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              adv,
    input  logic [LEN_W-1:0]  adv_len,
    output logic [ADDR_W-1:0] off,
    output logic [LEN_W-1:0]  len_next,
    output logic              final_burst
);

    logic [ADDR_W-1:0] off_q;
    logic [ADDR_W-1:0] off_d;
    logic [ADDR_W-1:0] off_eff;
    logic [ADDR_W-1:0] left;

    always_comb begin
        off_d = off_q;
        if (clr) begin
            off_d = '0;
        end else if (adv) begin
            off_d = off_q + ADDR_W'(adv_len);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            off_q <= '0;
        end else begin
            off_q <= off_d;
        end
    end

    assign off_eff     = clr ? '0 : off_q;
    assign left        = ADDR_W'(FRAME_WORDS) - off_eff;
    assign len_next    = LEN_W'(burst_len_min(32'(left), BURST_LEN));
    assign final_burst = (32'(left) <= BURST_LEN);
    assign off         = off_eff;

endmodule

// File: rtl/lcd_fb_arbiter.sv
// Frame-buffer port arbiter: display reads vs camera writes with ping-pong banks.
//   state   | meaning
//   IDLE    | apply pending frame starts, arbitrate
//   RD_CMD  | read command presented, waiting for mem_ack
//   RD_WAIT | read burst accepted, waiting for mem_done
//   WR_CMD  | write command presented, waiting for mem_ack
//   WR_WAIT | write burst accepted, waiting for mem_done
module lcd_fb_arbiter
    import fb_arb_pkg::*;
#(
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    parameter int unsigned FIFO_LW     = DEF_FIFO_LW,
    parameter int unsigned LEN_W       = DEF_LEN_W,
    parameter int unsigned FRAME_WORDS = DEF_FRAME_WORDS,
    parameter int unsigned BURST_LEN   = DEF_BURST_LEN,
    parameter int unsigned BANK_OFFSET = DEF_BANK_OFFSET,
    parameter int unsigned RD_LOW_TH   = DEF_RD_LOW_TH,
    parameter int unsigned MAX_RD_RUN  = DEF_MAX_RD_RUN
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               lcd_frame_start,
    input  logic [FIFO_LW-1:0] rd_fifo_level,
    input  logic               cam_frame_start,
    input  logic [FIFO_LW-1:0] wr_fifo_level,
    output logic               mem_req,
    output logic               mem_wr,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [LEN_W-1:0]   mem_len,
    input  logic               mem_ack,
    input  logic               mem_done,
    output logic               rd_bank,
    output logic               wr_bank,
    output logic               frame_drop,
    output logic               busy
);

    localparam int unsigned RUN_W = $clog2(MAX_RD_RUN + 1);

    arb_state_e        state_q, state_d;
    logic              lcd_pend_q, lcd_pend_d;
    logic              cam_pend_q, cam_pend_d;
    logic              rd_active_q, rd_active_d;
    logic              wr_active_q, wr_active_d;
    logic              last_done_bank_q, last_done_bank_d;
    logic              rd_bank_q, rd_bank_d;
    logic              wr_bank_q, wr_bank_d;
    logic [RUN_W-1:0]  rd_run_q, rd_run_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_wr_q, mem_wr_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [LEN_W-1:0]  mem_len_q, mem_len_d;
    logic              frame_drop_q, frame_drop_d;
    logic              busy_q, busy_d;

    logic              lcd_apply, cam_apply;
    logic              rd_bank_eff, wr_bank_eff;
    logic              rd_need, wr_need;
    logic              rd_cmplt, wr_cmplt;
    logic [ADDR_W-1:0] rd_off, wr_off;
    logic [LEN_W-1:0]  rd_len, wr_len;
    logic              rd_final, wr_final;

    function automatic logic [ADDR_W-1:0] bank_addr(input logic bank,
                                                    input logic [ADDR_W-1:0] off);
        return (bank ? ADDR_W'(BANK_OFFSET) : '0) + off;
    endfunction

    fb_frame_counter #(
        .ADDR_W(ADDR_W), .LEN_W(LEN_W), .FRAME_WORDS(FRAME_WORDS), .BURST_LEN(BURST_LEN)
    ) u_rd_cnt (
        .clk(clk), .rst(rst), .clr(lcd_apply), .adv(rd_cmplt), .adv_len(mem_len_q),
        .off(rd_off), .len_next(rd_len), .final_burst(rd_final)
    );

    fb_frame_counter #(
        .ADDR_W(ADDR_W), .LEN_W(LEN_W), .FRAME_WORDS(FRAME_WORDS), .BURST_LEN(BURST_LEN)
    ) u_wr_cnt (
        .clk(clk), .rst(rst), .clr(cam_apply), .adv(wr_cmplt), .adv_len(mem_len_q),
        .off(wr_off), .len_next(wr_len), .final_burst(wr_final)
    );

    // Frame starts land first so arbitration in the same cycle sees the new bank/offset.
    assign lcd_apply   = (state_q == ST_IDLE) && lcd_pend_q;
    assign cam_apply   = (state_q == ST_IDLE) && cam_pend_q;
    assign rd_bank_eff = lcd_apply ? last_done_bank_q : rd_bank_q;
    assign wr_bank_eff = (cam_apply && !wr_active_q) ? ~rd_bank_eff : wr_bank_q;
    assign rd_need     = (lcd_apply || rd_active_q) && (32'(rd_fifo_level) < RD_LOW_TH);
    assign wr_need     = (cam_apply || wr_active_q) && (32'(wr_fifo_level) >= 32'(wr_len));
    assign rd_cmplt    = mem_done && ((state_q == ST_RD_WAIT) || (state_q == ST_RD_CMD && mem_ack));
    assign wr_cmplt    = mem_done && ((state_q == ST_WR_WAIT) || (state_q == ST_WR_CMD && mem_ack));

    always_comb begin
        state_d          = state_q;
        lcd_pend_d       = lcd_frame_start || (lcd_pend_q && !lcd_apply);
        cam_pend_d       = cam_frame_start || (cam_pend_q && !cam_apply);
        rd_active_d      = rd_active_q;
        wr_active_d      = wr_active_q;
        last_done_bank_d = last_done_bank_q;
        rd_bank_d        = rd_bank_eff;
        wr_bank_d        = wr_bank_eff;
        rd_run_d         = rd_run_q;
        mem_req_d        = mem_req_q;
        mem_wr_d         = mem_wr_q;
        mem_addr_d       = mem_addr_q;
        mem_len_d        = mem_len_q;
        frame_drop_d     = 1'b0;

        if (lcd_apply) rd_active_d = 1'b1;
        if (cam_apply) begin
            frame_drop_d = wr_active_q;
            wr_active_d  = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (wr_need && (!rd_need || rd_run_q == RUN_W'(MAX_RD_RUN))) begin
                    state_d    = ST_WR_CMD;
                    mem_req_d  = 1'b1;
                    mem_wr_d   = 1'b1;
                    mem_addr_d = bank_addr(wr_bank_eff, wr_off);
                    mem_len_d  = wr_len;
                    rd_run_d   = '0;
                end else if (rd_need) begin
                    state_d    = ST_RD_CMD;
                    mem_req_d  = 1'b1;
                    mem_wr_d   = 1'b0;
                    mem_addr_d = bank_addr(rd_bank_eff, rd_off);
                    mem_len_d  = rd_len;
                    rd_run_d   = wr_need ? rd_run_q + 1'b1 : '0;
                end else begin
                    rd_run_d   = '0;
                end
            end
            ST_RD_CMD, ST_WR_CMD: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    if (mem_done)                 state_d = ST_IDLE;
                    else if (state_q == ST_RD_CMD) state_d = ST_RD_WAIT;
                    else                          state_d = ST_WR_WAIT;
                end
            end
            ST_RD_WAIT, ST_WR_WAIT: begin
                if (mem_done) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (rd_cmplt && rd_final) rd_active_d = 1'b0;
        if (wr_cmplt && wr_final) begin
            wr_active_d      = 1'b0;
            last_done_bank_d = wr_bank_q;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= ST_IDLE;
            lcd_pend_q       <= 1'b0;
            cam_pend_q       <= 1'b0;
            rd_active_q      <= 1'b0;
            wr_active_q      <= 1'b0;
            last_done_bank_q <= 1'b0;
            rd_bank_q        <= 1'b0;
            wr_bank_q        <= 1'b1;
            rd_run_q         <= '0;
            mem_req_q        <= 1'b0;
            mem_wr_q         <= 1'b0;
            mem_addr_q       <= '0;
            mem_len_q        <= '0;
            frame_drop_q     <= 1'b0;
            busy_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            lcd_pend_q       <= lcd_pend_d;
            cam_pend_q       <= cam_pend_d;
            rd_active_q      <= rd_active_d;
            wr_active_q      <= wr_active_d;
            last_done_bank_q <= last_done_bank_d;
            rd_bank_q        <= rd_bank_d;
            wr_bank_q        <= wr_bank_d;
            rd_run_q         <= rd_run_d;
            mem_req_q        <= mem_req_d;
            mem_wr_q         <= mem_wr_d;
            mem_addr_q       <= mem_addr_d;
            mem_len_q        <= mem_len_d;
            frame_drop_q     <= frame_drop_d;
            busy_q           <= busy_d;
        end
    end

    assign mem_req    = mem_req_q;
    assign mem_wr     = mem_wr_q;
    assign mem_addr   = mem_addr_q;
    assign mem_len    = mem_len_q;
    assign rd_bank    = rd_bank_q;
    assign wr_bank    = wr_bank_q;
    assign frame_drop = frame_drop_q;
    assign busy       = busy_q;

endmodule
